// File: rtl/qam_fifo_ctrl_if.sv
// Handshake and memory-side bundle for qam_fifo_ctrl.
// master = the controller, slave = requesters / memory / consumer.
`timescale 1ns/1ps
interface qam_fifo_ctrl_if;
  logic       src0_valid;
  logic       src1_valid;
  logic [7:0] src0_data;
  logic [7:0] src1_data;
  logic       src0_ready;
  logic       src1_ready;
  logic       mem_write_enable;
  logic [3:0] mem_write_pointer;
  logic [7:0] mem_data_in;
  logic       mem_read_enable;
  logic [3:0] mem_read_pointer;
  logic [7:0] mem_data_out;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       last_grant;

  modport master (
    input  src0_valid, src1_valid, src0_data, src1_data, mem_data_out, out_ready,
    output src0_ready, src1_ready, mem_write_enable, mem_write_pointer, mem_data_in,
           mem_read_enable, mem_read_pointer, full, empty, level, out_valid, out_data,
           last_grant
  );

  modport slave (
    output src0_valid, src1_valid, src0_data, src1_data, mem_data_out, out_ready,
    input  src0_ready, src1_ready, mem_write_enable, mem_write_pointer, mem_data_in,
           mem_read_enable, mem_read_pointer, full, empty, level, out_valid, out_data,
           last_grant
  );
endinterface

// File: rtl/qam_fifo_ctrl.sv
// Two-requester round-robin front end for a 4-entry external memory FIFO,
// with a one-entry valid/ready output stage fed by the registered memory read port.
`timescale 1ns/1ps
module qam_fifo_ctrl (
  input  logic             clk,
  input  logic             reset,
  qam_fifo_ctrl_if.master  bus
);
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned LVL_W  = 3;
  localparam int unsigned DEPTH  = 4;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             out_valid_q, out_valid_d;
  logic             last_grant_q, last_grant_d;

  logic [LVL_W-1:0] level_c;
  logic             full_c, empty_c;
  logic             gnt0_c, gnt1_c;
  logic             wr_en_c, rd_en_c;

  // Occupancy flags come from the pointer registers only.
  always_comb begin
    level_c = LVL_W'(wptr_q - rptr_q);
    full_c  = (level_c == LVL_W'(DEPTH));
    empty_c = (level_c == '0);
  end

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    gnt0_c  = !full_c && bus.src0_valid && (!bus.src1_valid || last_grant_q);
    gnt1_c  = !full_c && bus.src1_valid && (!bus.src0_valid || !last_grant_q);
    wr_en_c = gnt0_c || gnt1_c;
    rd_en_c = !empty_c && (!out_valid_q || bus.out_ready);
  end

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (wr_en_c) begin
      wptr_d       = wptr_q + PTR_W'(1);
      last_grant_d = gnt1_c;
    end
    // A read refills the output stage in the same edge that may drain it.
    if (rd_en_c) begin
      rptr_d      = rptr_q + PTR_W'(1);
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.src0_ready        = gnt0_c;
  assign bus.src1_ready        = gnt1_c;
  assign bus.mem_write_enable  = wr_en_c;
  assign bus.mem_write_pointer = {(ADDR_W-IDX_W)'(0), wptr_q[IDX_W-1:0]};
  assign bus.mem_data_in       = gnt0_c ? bus.src0_data : bus.src1_data;
  assign bus.mem_read_enable   = rd_en_c;
  assign bus.mem_read_pointer  = {(ADDR_W-IDX_W)'(0), rptr_q[IDX_W-1:0]};
  assign bus.full              = full_c;
  assign bus.empty             = empty_c;
  assign bus.level             = level_c;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = bus.mem_data_out;
  assign bus.last_grant        = last_grant_q;
endmodule

// File: tb/tb_qam_fifo_ctrl.sv
// Bench for qam_fifo_ctrl: vector table, directed corner sequences and random
// backpressure, all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_qam_fifo_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qam_fifo_ctrl_if bus();
  qam_fifo_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural 16x8 memory with registered read data.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_write_pointer] <= bus.mem_data_in;
    if (bus.mem_read_enable)  bus.mem_data_out <= mem[bus.mem_read_pointer];
  end

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: bytes held in memory, output stage, grant history.
  logic [7:0] mq[$];
  logic [7:0] got_q[$];
  logic [7:0] sent_q[$];
  bit         ov_m, lg_m;
  logic [7:0] od_m;
  int         wcnt_m, rcnt_m;
  bit         g0_m, g1_m, re_m;
  bit         hold_prev;
  logic [7:0] hold_data;

  typedef struct {
    bit rst; bit v0; logic [7:0] d0; bit v1; logic [7:0] d1; bit ordy;
    bit e_r0; bit e_r1; int e_lvl; bit e_ov; logic [7:0] e_od; bit e_lg;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ov_m = 1'b0; lg_m = 1'b1; od_m = 8'h00;
    wcnt_m = 0; rcnt_m = 0; hold_prev = 1'b0;
  endtask

  task automatic drive_check(input bit rst, input bit v0, input logic [7:0] d0,
                             input bit v1, input logic [7:0] d1, input bit ordy);
    bit full_m;
    @(negedge clk);
    reset = rst;
    bus.src0_valid = v0; bus.src0_data = d0;
    bus.src1_valid = v1; bus.src1_data = d1;
    bus.out_ready  = ordy;
    if (rst) model_reset();
    #1;
    full_m = (mq.size() == 4);
    g0_m = !rst && !full_m && v0 && (!v1 || lg_m);
    g1_m = !rst && !full_m && v1 && (!v0 || !lg_m);
    re_m = !rst && (mq.size() != 0) && (!ov_m || ordy);
    chk("src0_ready", int'(bus.src0_ready), int'(g0_m));
    chk("src1_ready", int'(bus.src1_ready), int'(g1_m));
    chk("mem_write_enable", int'(bus.mem_write_enable), int'(g0_m || g1_m));
    if (g0_m || g1_m) chk("mem_data_in", int'(bus.mem_data_in), int'(g0_m ? d0 : d1));
    chk("mem_read_enable", int'(bus.mem_read_enable), int'(re_m));
    chk("level", int'(bus.level), mq.size());
    chk("full", int'(bus.full), int'(full_m));
    chk("empty", int'(bus.empty), int'(mq.size() == 0));
    chk("out_valid", int'(bus.out_valid), int'(ov_m));
    if (ov_m) chk("out_data", int'(bus.out_data), int'(od_m));
    chk("last_grant", int'(bus.last_grant), int'(lg_m));
    chk("wr_ptr", int'(bus.mem_write_pointer), wcnt_m % 4);
    chk("rd_ptr", int'(bus.mem_read_pointer), rcnt_m % 4);
    if (hold_prev && bus.out_valid) chk("out_data_stable", int'(bus.out_data), int'(hold_data));
    hold_prev = !rst && bus.out_valid && !ordy;
    hold_data = bus.out_data;
    if (!rst && bus.out_valid && ordy) got_q.push_back(bus.out_data);
  endtask

  task automatic clock_update(input bit rst, input logic [7:0] d0,
                              input logic [7:0] d1, input bit ordy);
    @(posedge clk);
    if (!rst) begin
      if (re_m) begin
        od_m = mq.pop_front(); ov_m = 1'b1; rcnt_m++;
      end else if (ov_m && ordy) begin
        ov_m = 1'b0;
      end
      if (g0_m || g1_m) begin
        mq.push_back(g0_m ? d0 : d1);
        lg_m = g1_m; wcnt_m++;
      end
    end
  endtask

  task automatic step(input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1, input bit ordy);
    drive_check(1'b0, v0, d0, v1, d1, ordy);
    clock_update(1'b0, d0, d1, ordy);
  endtask

  task automatic chk_got(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk(nm, int'(got_q[i]), int'(exp[i]));
  endtask

  initial begin
    logic [7:0] d0n, d1n, exp_q[$];
    int acc;

    // Single byte (rows 0-3), reset (row 4), contention (rows 5-11).
    tbl[0]  = '{0,1,8'hA5,0,8'h00,1, 1,0,0,0,8'h00,1};
    tbl[1]  = '{0,0,8'h00,0,8'h00,1, 0,0,1,0,8'h00,0};
    tbl[2]  = '{0,0,8'h00,0,8'h00,1, 0,0,0,1,8'hA5,0};
    tbl[3]  = '{0,0,8'h00,0,8'h00,1, 0,0,0,0,8'h00,0};
    tbl[4]  = '{1,0,8'h00,0,8'h00,1, 0,0,0,0,8'h00,1};
    tbl[5]  = '{0,1,8'h10,1,8'h20,1, 1,0,0,0,8'h00,1};
    tbl[6]  = '{0,1,8'h11,1,8'h20,1, 0,1,1,0,8'h00,0};
    tbl[7]  = '{0,1,8'h11,1,8'h21,1, 1,0,1,1,8'h10,1};
    tbl[8]  = '{0,1,8'h12,1,8'h21,1, 0,1,1,1,8'h20,0};
    tbl[9]  = '{0,0,8'h00,0,8'h00,1, 0,0,1,1,8'h11,1};
    tbl[10] = '{0,0,8'h00,0,8'h00,1, 0,0,0,1,8'h21,1};
    tbl[11] = '{0,0,8'h00,0,8'h00,1, 0,0,0,0,8'h00,1};

    reset = 1'b1;
    bus.src0_valid = 1'b0; bus.src1_valid = 1'b0;
    bus.src0_data = 8'h00; bus.src1_data = 8'h00; bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      drive_check(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy);
      chk($sformatf("tbl%0d_src0_ready", i), int'(bus.src0_ready), int'(tbl[i].e_r0));
      chk($sformatf("tbl%0d_src1_ready", i), int'(bus.src1_ready), int'(tbl[i].e_r1));
      chk($sformatf("tbl%0d_level", i), int'(bus.level), tbl[i].e_lvl);
      chk($sformatf("tbl%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), int'(bus.out_data), int'(tbl[i].e_od));
      chk($sformatf("tbl%0d_last_grant", i), int'(bus.last_grant), int'(tbl[i].e_lg));
      clock_update(tbl[i].rst, tbl[i].d0, tbl[i].d1, tbl[i].ordy);
    end

    // Fill: src1 streams with the consumer stalled.
    d1n = 8'h30;
    for (int c = 0; c < 8; c++) begin
      drive_check(1'b0, 1'b0, 8'h00, 1'b1, d1n, 1'b0);
      if (g1_m) d1n++;
      clock_update(1'b0, 8'h00, d1n - 8'(g1_m), 1'b0);
    end
    drive_check(1'b0, 1'b0, 8'h00, 1'b1, d1n, 1'b0);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_level", int'(bus.level), 4);
    chk("fill_src1_ready", int'(bus.src1_ready), 0);
    clock_update(1'b0, 8'h00, d1n, 1'b0);
    got_q.delete();
    repeat (8) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    chk_got("fill_drain", exp_q);

    // Random valids and backpressure over 20 bytes.
    got_q.delete(); sent_q.delete();
    d0n = 8'h40; d1n = 8'h80; acc = 0;
    for (int c = 0; c < 400 && got_q.size() < 20; c++) begin
      bit v0, v1, rdy;
      v0  = (acc < 20) && 1'($urandom_range(0, 1));
      v1  = (acc < 20) && 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      drive_check(1'b0, v0, d0n, v1, d1n, rdy);
      clock_update(1'b0, d0n, d1n, rdy);
      if (g0_m) begin sent_q.push_back(d0n); d0n++; acc++; end
      if (g1_m) begin sent_q.push_back(d1n); d1n++; acc++; end
    end
    chk_got("bp_order", sent_q);

    // Wrap: 12 bytes streamed through with the consumer always ready.
    got_q.delete(); sent_q.delete();
    d0n = 8'h60; acc = 0;
    for (int c = 0; c < 60 && got_q.size() < 12; c++) begin
      drive_check(1'b0, acc < 12, d0n, 1'b0, 8'h00, 1'b1);
      clock_update(1'b0, d0n, 8'h00, 1'b1);
      if (g0_m) begin sent_q.push_back(d0n); d0n++; acc++; end
    end
    chk_got("wrap_order", sent_q);

    // Reset mid-stream at level 3.
    d0n = 8'h90; acc = 0;
    for (int c = 0; c < 10 && acc < 4; c++) begin
      drive_check(1'b0, 1'b1, d0n, 1'b0, 8'h00, 1'b0);
      clock_update(1'b0, d0n, 8'h00, 1'b0);
      if (g0_m) begin d0n++; acc++; end
    end
    @(negedge clk);
    bus.src0_valid = 1'b0;
    chk("pre_reset_level", int'(bus.level), 3);
    #2 reset = 1'b1;
    #1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_last_grant", int'(bus.last_grant), 1);
    chk("rst_src0_ready", int'(bus.src0_ready), 0);
    model_reset();
    @(posedge clk);
    got_q.delete();
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_q = '{8'h77};
    chk_got("post_reset", exp_q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
